shift_issue_unit: RTL and testbench
===================================

// Module: shift_issue_unit
// PURPOSE
//  Command front-end and result stage for the 8-bit combinational barrel shifter.
//  - Buffers shift commands {din, shamt, LR, AL} from a valid/ready producer.
//  - Drives the head command onto the shifter and registers the shifter's result.
//  - Presents the result on a valid/ready consumer port and counts completed ops.
// PARAMETERS
//  DEPTH    4   command FIFO entries (power of 2, >=2)
//  CNT_W    16  width of completed-operation counter
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  flush      in   1      sync clear of FIFO and result register (not counter)
//  in_valid   in   1      command offered
//  in_ready   out  1      FIFO can accept; = (count < DEPTH), registered-state only
//  in_din     in   8      operand
//  in_shamt   in   3      shift amount 0..7
//  in_lr      in   1      1 = shift left, 0 = shift right
//  in_al      in   1      right shifts only: 1 = arithmetic (MSB fill), 0 = logical
//  bs_din     out  8      to shifter: head operand (0 when FIFO empty)
//  bs_shamt   out  3      to shifter: head shamt (0 when empty)
//  bs_lr      out  1      to shifter: head LR (0 when empty)
//  bs_al      out  1      to shifter: head AL (0 when empty)
//  bs_dout    in   8      from shifter: combinational result of bs_* inputs
//  out_valid  out  1      result register holds unconsumed result
//  out_ready  in   1      consumer accepts result
//  out_data   out  8      registered shift result
//  op_count   out  CNT_W  results handed off (out_valid & out_ready), wraps
// BEHAVIOUR
//  Reset: FIFO empty (count=0), in_ready=1, out_valid=0, out_data=0, op_count=0.
//  Push: in_valid & in_ready at edge -> write tail, count+1.
//  Issue: head valid & (!out_valid | out_ready) at edge -> out_data<=bs_dout,
//    out_valid<=1, pop head. No bubble on back-to-back issue.
//  Drain: out_ready & out_valid & no issue at the same edge -> out_valid<=0.
//  Latency: command pushed into empty FIFO at edge N -> out_valid high after N+1.
//  Throughput: 1 result/cycle when out_ready held high.
//  Simultaneous push+pop: count unchanged, both pointers advance; allowed when
//    not full. When full, in_ready=0 even if a pop occurs that cycle.
//  Pointers wrap modulo DEPTH; full/empty from count, not pointer compare.
//  Ordering: results leave strictly in command order.
//  Shift semantics (enforced by shifter, checked by bench): left fills 0;
//    right logical fills 0; right arithmetic fills din[7]; shamt=0 -> din.
//  flush (priority over push/issue, below rst): count=0, pointers=0,
//    out_valid=0, out_data=0; in_ready=1 next cycle; op_count kept.
//  rst mid-operation: same as reset values; in-flight commands discarded.
//  bs_* are combinational from FIFO head only; no path from in_* or out_ready.
// STRUCTURE
//  shift_pkg: typedef shift_cmd_t {din[7:0], shamt[2:0], lr, al};
//    localparams SHIFT_W=8, SHAMT_W=3.
//  Sub-module shift_cmd_fifo (DEPTH, shift_cmd_t): sync FIFO with push/pop,
//    head, count, flush; top holds result register, handshake, counter.
//  Barrel shifter instantiated beside this block in the parent, not inside.
// TESTING
//  1 rst; push {din=8'hB4,shamt=2,lr=1,al=0} -> out_data=8'hD0 two edges later.
//  2 {8'hB4,3,lr=0,al=1} -> 8'hF6; {8'hB4,3,lr=0,al=0} -> 8'h16; shamt=0 -> 8'hB4.
//  3 out_ready=0, push 5 cmds -> in_ready=0 after 4 (+1 in result reg);
//    release out_ready -> 5 results in order, 1/cycle, op_count=5.
//  4 random in_valid/out_ready 1000 cmds vs reference model -> no loss, dup, or
//    reorder; op_count = results accepted mod 2^CNT_W.
//  5 flush with 3 queued + out_valid=1 -> next cycle out_valid=0, in_ready=1,
//    op_count unchanged; next command result correct.
//  6 rst asserted mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and widths for the shift command front-end.
package shift_pkg;

    localparam int unsigned SHIFT_W = 8;
    localparam int unsigned SHAMT_W = 3;

    typedef struct packed {
        logic [SHIFT_W-1:0] din;
        logic [SHAMT_W-1:0] shamt;
        logic               lr;
        logic               al;
    } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO; occupancy count drives full/empty so pointers may simply wrap.
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  shift_cmd_t push_data,
    input  logic       pop,
    output shift_cmd_t head,
    output logic       head_valid,
    output logic       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_W + 1;

    shift_cmd_t          mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                empty;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_BITS'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_valid = !empty;
    assign head       = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/shift_issue_unit.sv
// Command buffer, issue handshake and registered result stage for an external barrel shifter.
module shift_issue_unit
    import shift_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHIFT_W-1:0] in_din,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_lr,
    input  logic               in_al,
    output logic [SHIFT_W-1:0] bs_din,
    output logic [SHAMT_W-1:0] bs_shamt,
    output logic               bs_lr,
    output logic               bs_al,
    input  logic [SHIFT_W-1:0] bs_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHIFT_W-1:0] out_data,
    output logic [CNT_W-1:0]   op_count
);

    shift_cmd_t in_cmd;
    shift_cmd_t head;
    logic       head_valid;
    logic       full;
    logic       issue;
    logic       handoff;

    assign in_cmd = '{din: in_din, shamt: in_shamt, lr: in_lr, al: in_al};

    shift_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (in_valid),
        .push_data (in_cmd),
        .pop       (issue),
        .head      (head),
        .head_valid(head_valid),
        .full      (full)
    );

    assign in_ready = !full;
    assign issue    = head_valid && (!out_valid || out_ready);
    assign handoff  = out_valid && out_ready;

    assign bs_din   = head.din;
    assign bs_shamt = head.shamt;
    assign bs_lr    = head.lr;
    assign bs_al    = head.al;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            op_count  <= '0;
        end else if (flush) begin
            // The held result is discarded, so it is not counted as handed off.
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (issue) begin
                out_data  <= bs_dout;
                out_valid <= 1'b1;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
            if (handoff) op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_issue_unit.sv
// Randomized bench: queue-based reference model of the command/result path plus a shifter model.
module tb_shift_issue_unit;
    import shift_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_din = '0;
    logic [2:0]       in_shamt = '0;
    logic             in_lr = 1'b0;
    logic             in_al = 1'b0;
    logic [7:0]       bs_din;
    logic [2:0]       bs_shamt;
    logic             bs_lr;
    logic             bs_al;
    logic [7:0]       bs_dout;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    shift_cmd_t       cq[$];
    logic             m_ov = 1'b0;
    logic [7:0]       m_od = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    int               m_pushes = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_shift(logic [7:0] d, int s, logic lr, logic al);
        int v;
        v = int'(d);
        if (lr) return 8'((v << s) & 255);
        if (al && d[7]) v = v - 256;
        return 8'(v >>> s);
    endfunction

    assign bs_dout = ref_shift(bs_din, int'(bs_shamt), bs_lr, bs_al);

    shift_issue_unit #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_din   (in_din),
        .in_shamt (in_shamt),
        .in_lr    (in_lr),
        .in_al    (in_al),
        .bs_din   (bs_din),
        .bs_shamt (bs_shamt),
        .bs_lr    (bs_lr),
        .bs_al    (bs_al),
        .bs_dout  (bs_dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .op_count (op_count)
    );

    function automatic shift_cmd_t mk(logic [7:0] d, logic [2:0] s, logic lr, logic al);
        shift_cmd_t c;
        c.din = d; c.shamt = s; c.lr = lr; c.al = al;
        return c;
    endfunction

    function automatic shift_cmd_t rand_cmd();
        return mk(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    // One clock cycle: apply inputs, compare DUT against model, advance model across the edge.
    task automatic cycle(input logic iv, input shift_cmd_t c, input logic ordy, input logic fl);
        shift_cmd_t hd;
        bit         push, issue, handoff;
        in_valid = iv; in_din = c.din; in_shamt = c.shamt; in_lr = c.lr; in_al = c.al;
        out_ready = ordy; flush = fl;
        #1;
        hd = (cq.size() > 0) ? cq[0] : '0;
        n_checks++;
        if (in_ready !== (cq.size() < DEPTH)) begin
            n_errors++;
            $display("FAIL in_ready: got %b want %b", in_ready, cq.size() < DEPTH);
        end
        n_checks++;
        if (out_valid !== m_ov) begin
            n_errors++;
            $display("FAIL out_valid: got %b want %b", out_valid, m_ov);
        end
        if (m_ov) begin
            n_checks++;
            if (out_data !== m_od) begin
                n_errors++;
                $display("FAIL out_data: got %h want %h", out_data, m_od);
            end
        end
        n_checks++;
        if (op_count !== m_cnt) begin
            n_errors++;
            $display("FAIL op_count: got %0d want %0d", op_count, m_cnt);
        end
        n_checks++;
        if ({bs_din, bs_shamt, bs_lr, bs_al} !== {hd.din, hd.shamt, hd.lr, hd.al}) begin
            n_errors++;
            $display("FAIL bs_head: got %h/%0d/%b/%b want %h/%0d/%b/%b", bs_din, bs_shamt,
                     bs_lr, bs_al, hd.din, hd.shamt, hd.lr, hd.al);
        end
        if (fl) begin
            cq.delete();
            m_ov = 1'b0;
            m_od = '0;
        end else begin
            push    = iv && (cq.size() < DEPTH);
            issue   = (cq.size() > 0) && (!m_ov || ordy);
            handoff = m_ov && ordy;
            if (handoff) m_cnt = m_cnt + 1'b1;
            if (issue) begin
                hd   = cq.pop_front();
                m_od = ref_shift(hd.din, int'(hd.shamt), hd.lr, hd.al);
                m_ov = 1'b1;
            end else if (handoff) begin
                m_ov = 1'b0;
            end
            if (push) begin
                cq.push_back(c);
                m_pushes++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({in_ready, out_valid, out_data, op_count} !== {1'b1, 1'b0, 8'h00, 16'h0000}) begin
            n_errors++;
            $display("FAIL %s: got rdy=%b ov=%b data=%h cnt=%0d want rdy=1 ov=0 data=00 cnt=0",
                     tag, in_ready, out_valid, out_data, op_count);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cq.delete(); m_ov = 1'b0; m_od = '0; m_cnt = '0;
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset");
    endtask

    task automatic test_shift_modes();
        shift_cmd_t cmds[4];
        logic [7:0] want[4];
        cmds[0] = mk(8'hB4, 3'd2, 1'b1, 1'b0); want[0] = 8'hD0;
        cmds[1] = mk(8'hB4, 3'd3, 1'b0, 1'b1); want[1] = 8'hF6;
        cmds[2] = mk(8'hB4, 3'd3, 1'b0, 1'b0); want[2] = 8'h16;
        cmds[3] = mk(8'hB4, 3'd0, 1'b0, 1'b1); want[3] = 8'hB4;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, cmds[i], 1'b1, 1'b0);
            cycle(1'b0, '0, 1'b0, 1'b0);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== want[i]) begin
                n_errors++;
                $display("FAIL shift_mode%0d: got ov=%b data=%h want ov=1 data=%h", i, out_valid,
                         out_data, want[i]);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        logic [CNT_W-1:0] base;
        base = m_cnt;
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_cmd(), 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_ready: got %b want 0", in_ready);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (op_count !== base + CNT_W'(5)) begin
            n_errors++;
            $display("FAIL backpressure_count: got %0d want %0d", op_count, base + CNT_W'(5));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) cycle(1'b1, rand_cmd(), 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL back_to_back_valid: got %b want 1", out_valid);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [CNT_W-1:0] base;
        int start, guard;
        base = m_cnt; start = m_pushes; guard = 0;
        while ((m_pushes - start) < 1000 && guard < 20000) begin
            cycle(1'($urandom_range(0, 9) < 7), rand_cmd(), 1'($urandom_range(0, 9) < 6), 1'b0);
            guard++;
        end
        for (int i = 0; i < DEPTH + 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if ((m_pushes - start) != 1000) begin
            n_errors++;
            $display("FAIL random_timeout: got %0d pushes want 1000", m_pushes - start);
        end
        n_checks++;
        if (op_count !== base + CNT_W'(1000) || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL random_total: got cnt=%0d ov=%b want cnt=%0d ov=0", op_count,
                     out_valid, base + CNT_W'(1000));
        end
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] base;
        base = m_cnt;
        for (int i = 0; i < 4; i++) cycle(1'b1, rand_cmd(), 1'b0, 1'b0);
        cycle(1'b1, rand_cmd(), 1'b0, 1'b1);
        n_checks++;
        if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 8'h00} || op_count !== base) begin
            n_errors++;
            $display("FAIL flush: got ov=%b rdy=%b data=%h cnt=%0d want ov=0 rdy=1 data=00 cnt=%0d",
                     out_valid, in_ready, out_data, op_count, base);
        end
        cycle(1'b1, mk(8'h81, 3'd1, 1'b0, 1'b1), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC0) begin
            n_errors++;
            $display("FAIL post_flush: got ov=%b data=%h want ov=1 data=c0", out_valid, out_data);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 20; i++) cycle(1'b1, rand_cmd(), 1'($urandom), 1'b0);
        do_reset();
        check_reset_values("rst_mid");
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        test_reset();
        test_shift_modes();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_flush();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
